// File: rtl/bram_stream_pkg.sv
// Shared types and sizing for the BRAM stream reader.
// Imported by the reader top and its output buffer.
package bram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } rd_state_t;

   localparam int BUF_DEPTH = 2;
   localparam int CNTW      = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_2deep.sv
// Two-entry FIFO holding BRAM words plus their last tag.
// Simultaneous push and pop are allowed, even when full.
module fifo_2deep
   import bram_stream_pkg::*;
#(
   parameter int W = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [W-1:0]    din,
   output logic [W-1:0]    dout,
   output logic            empty,
   output logic            full,
   output logic [CNTW-1:0] count
);

   logic [W-1:0] mem [BUF_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNTW'(BUF_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy; reset clears the head so dout reads 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + CNTW'(do_push) - CNTW'(do_pop);
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a block of BRAM words and emits them as a valid/ready stream.
// Read latency and backpressure are absorbed by a 2-entry buffer.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 256,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDRW-1:0] base,
   input  logic [ADDRW:0]   len,
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] bram_addr,
   input  logic [WIDTH-1:0] bram_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   rd_state_t        state;
   rd_state_t        state_nx;
   logic [ADDRW-1:0] addr_q;
   logic [ADDRW-1:0] addr_inc;
   logic [ADDRW:0]   remaining;
   logic [ADDRW:0]   beats;
   logic             pending;
   logic             last_pend;
   logic             issue;
   logic             pop;
   logic [CNTW:0]    credit;
   logic [CNTW-1:0]  count;
   logic             empty;
   logic             full;
   logic [WIDTH:0]   head;

   assign pop       = out_valid & out_ready;
   assign credit    = {1'b0, count} + (CNTW + 1)'(pending);
   assign issue     = (state == READ) && (remaining != '0)
                      && ((credit < (CNTW + 1)'(BUF_DEPTH)) || pop);
   assign addr_inc  = (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
   assign bram_addr = addr_q;
   assign out_valid = ~empty;
   assign out_data  = head[WIDTH-1:0];
   assign out_last  = head[WIDTH] & out_valid;

   fifo_2deep #(
      .W(WIDTH + 1)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (pending),
      .pop  (pop),
      .din  ({last_pend, bram_data}),
      .dout (head),
      .empty(empty),
      .full (full),
      .count(count)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: read until all issued, drain until last pop, pulse done.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = (len != '0) ? READ : DONE;
            end
         end
         READ: begin
            if (issue && (remaining == (ADDRW + 1)'(1))) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (beats == (ADDRW + 1)'(1))) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (1'b1)
         (state == READ),
         (state == DRAIN): busy = 1'b1;
         (state == DONE):  done = 1'b1;
         default: ;
      endcase
   end

   // Address, counters and the in-flight read marker with its last tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         remaining <= '0;
         beats     <= '0;
         pending   <= 1'b0;
         last_pend <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            addr_q    <= base;
            remaining <= len;
            beats     <= len;
         end
         if (issue) begin
            addr_q    <= addr_inc;
            remaining <= remaining - 1'b1;
            pending   <= 1'b1;
            last_pend <= (remaining == (ADDRW + 1)'(1));
         end else begin
            pending   <= 1'b0;
         end
         if (pop && (beats != '0)) begin
            beats <= beats - 1'b1;
         end
      end
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Reader-side front end for `bram_sdp`: drives the BRAM read port and turns a block of words into a valid/ready stream with a last marker.
- On `start`, reads `len` consecutive words beginning at `base`.
- Absorbs the 1-cycle synchronous read latency and downstream backpressure with a 2-entry buffer, so no word is lost or duplicated.
- Sits between the framebuffer/line-buffer BRAM and display or DMA consumers.

Parameters:
- WIDTH, 8, data word width; must match the attached `bram_sdp`.
- DEPTH, 256, BRAM depth in words.
- ADDRW, $clog2(DEPTH), local; address width.

Ports:
- clk  in  1  system clock; same clock drives `clk_read` of the BRAM.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- base  in  ADDRW  first word address, captured on accepted start.
- len  in  ADDRW+1  word count, 0..DEPTH, captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the block is complete.
- bram_addr  out  ADDRW  to BRAM `addr_read`; registered.
- bram_data  in  WIDTH  from BRAM `data_out`.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  high with the final word of the block.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; busy=0, done=0, out_valid=0, out_last=0, bram_addr=0.
  - out_data=0; buffer count=0; pending=0; remaining=0.
- States:
  - IDLE: wait for start.
    - start & len≠0 → READ. Capture addr_q=base, remaining=len, beats=len.
    - start & len=0 → DONE.
  - READ: issue reads. When remaining reaches 0 → DRAIN.
  - DRAIN: no further reads. When the last word handshakes → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- start outside IDLE is ignored. base and len are not re-sampled.
- Read issue:
  - issue = (state==READ) & remaining≠0 & ((count+pending)<2 | pop).
  - pop = out_valid & out_ready.
  - bram_addr always equals addr_q.
  - On issue: addr_q increments modulo DEPTH (wraps DEPTH-1→0), remaining decrements, pending←1.
  - Without issue: pending←0.
- Data path:
  - When pending=1, `bram_data` in that cycle is the word for the previously issued address; it is pushed into the buffer at the next edge.
  - Buffer: 2-entry FIFO; push and pop in the same cycle are legal.
  - The credit rule guarantees the buffer never overflows.
- Output:
  - out_valid = buffer non-empty.
  - out_data and out_last come from the head entry.
  - The last tag is set on the word whose issue took remaining from 1→0.
  - out_data and out_valid stay stable while out_ready=0.
- Latency:
  - Edge 0: start accepted.
  - Cycle 1: first read issued.
  - Cycle 3: out_valid=1.
  - With out_ready held high, throughput is 1 word/cycle.
- Completion:
  - beats decrements on each pop.
  - The pop of the last word moves the FSM to DONE; done is high the next cycle and busy drops the same cycle.
- rst mid-block:
  - Buffer contents discarded; out_valid=0 on the cycle after reset.
  - No done pulse is produced.
- len=DEPTH: reads all words once; the address ends wrapped back to base.

Decomposition:
- Package `bram_stream_pkg`:
  - `typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t`.
  - localparam `BUF_DEPTH=2`.
- Sub-module `fifo_2deep`:
  - Parameter `WIDTH+1`, carrying data plus the last bit.
  - Ports: push, pop, din, dout, empty, full, count.

Test Plan:
- **Basic block:** memory[i]=i. start with base=4, len=3, out_ready=1.
  - out_valid first at cycle 3; data 4,5,6; out_last only on 6.
  - done pulse one cycle after the beat carrying 6; busy low in that same cycle.
- **Wrap-around:** DEPTH=256, base=254, len=4.
  - bram_addr sequence 254, 255, 0, 1; output data matches memory in that order; last on the word from address 1.
- **Backpressure:** base=0, len=8, out_ready toggles 1,0,0,1 repeating.
  - All 8 words delivered in order, none duplicated.
  - Never more than 2 reads outstanding plus buffered.
  - out_data stable during every ready=0 cycle.
- **Zero length and busy start:** start with len=0 → done one cycle later, out_valid never high.
  - start pulsed mid-block → ignored; the block completes with the original len.
- **Reset mid-operation:** len=16, assert rst after 5 handshakes.
  - Next cycle: out_valid=0, busy=0, bram_addr=0; no done pulse.
  - A new start with base=0, len=2 then works normally.
- **Full depth:** len=256, base=10, out_ready=1.
  - 256 beats at 1/cycle after the initial 3-cycle latency; last on data from address 9.
